uart_pixel_assembler: RTL and testbench
=======================================

UART_PIXEL_ASSEMBLER -- requirements
Module: uart_pixel_assembler

Interface
REQ-001 SHALL have parameter PIXEL_COUNT, default 172800, number of RAM pixel locations.
REQ-002 SHALL have parameter BYTES_PER_PIXEL, default 3, range 1..4, bytes per pixel word.
REQ-003 SHALL have parameter LSB_FIRST, default 1; 1 = first byte to bits [7:0], 0 = first byte to the top byte.
REQ-004 SHALL have parameter BYTE_TIMEOUT, default 1000000, clk cycles allowed between bytes of one pixel.
REQ-005 SHALL derive AW = $clog2(PIXEL_COUNT) and DW = 8*BYTES_PER_PIXEL.
REQ-006 clk  input  1  system clock, all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high.
REQ-008 rx_valid  input  1  one-cycle strobe; data_in valid.
REQ-009 data_in  input  8  received byte.
REQ-010 frame_sync  input  1  one-cycle strobe; restart frame at address 0.
REQ-011 wr_ready  input  1  RAM accepts write this cycle.
REQ-012 wr_en  output  1  write request, held until accepted.
REQ-013 wr_data  output  DW  assembled pixel.
REQ-014 wr_addr  output  AW  pixel address.
REQ-015 frame_done  output  1  one-cycle pulse, last pixel written.
REQ-016 byte_drop  output  1  one-cycle pulse, byte lost to overflow.
REQ-017 timeout_err  output  1  one-cycle pulse, partial pixel discarded.

Function
REQ-018 SHALL implement states COLLECT and WRITE, plus a byte counter 0..BYTES_PER_PIXEL-1 and a one-entry skid register (byte + valid).
REQ-019 In COLLECT, each accepted byte SHALL go to byte lane k (k = count when LSB_FIRST=1, BYTES_PER_PIXEL-1-count otherwise); count increments.
REQ-020 When the byte filling the last lane is accepted in cycle N, the state SHALL become WRITE and wr_en SHALL be 1 in cycle N+1, with wr_data/wr_addr stable until acceptance.
REQ-021 A write SHALL complete in the cycle with wr_en=1 and wr_ready=1; next cycle: wr_en=0, state COLLECT, count 0, wr_addr incremented.
REQ-022 wr_addr SHALL wrap from PIXEL_COUNT-1 to 0 on completion; frame_done SHALL pulse in the cycle after that completion.
REQ-023 A byte arriving in WRITE SHALL be stored in the skid register if it is empty; if it is full, the byte SHALL be discarded and byte_drop pulsed the next cycle.
REQ-024 On return to COLLECT, a valid skid byte SHALL be consumed as lane-0 byte in that first COLLECT cycle, before any new rx_valid byte; a simultaneous rx_valid byte SHALL be taken as the following lane (or go to skid if that completes a pixel).
REQ-025 With BYTES_PER_PIXEL=1 each byte SHALL complete a pixel directly (no counter wrap beyond 0).
REQ-026 A timeout counter SHALL run in COLLECT while count>0, clearing on every accepted byte; on reaching BYTE_TIMEOUT, count SHALL clear, lanes clear, address hold, timeout_err pulse one cycle.
REQ-027 No timeout SHALL occur in WRITE or when count=0.
REQ-028 frame_sync SHALL take priority over everything: next cycle count=0, skid empty, wr_addr=0, state COLLECT, wr_en=0 (pending write abandoned); a byte arriving with frame_sync SHALL be ignored without byte_drop.
REQ-029 data_in SHALL be ignored when rx_valid=0.

Reset
REQ-030 On reset: state COLLECT, count 0, skid empty, wr_data 0, wr_addr 0, wr_en 0, frame_done 0, byte_drop 0, timeout_err 0, timeout counter 0.
REQ-031 Reset mid-pixel or mid-write SHALL discard all partial data; no wr_en after reset until a full new pixel arrives.

Verification
REQ-032 Defaults, wr_ready=1, bytes 0x11,0x22,0x33 -> one cycle after the third byte: wr_en=1, wr_data=0x332211, wr_addr=0; then wr_addr=1.
REQ-033 LSB_FIRST=0, same bytes -> wr_data=0x112233.
REQ-034 PIXEL_COUNT=4, 4 pixels -> addresses 0,1,2,3; frame_done one pulse after 4th write; wr_addr=0.
REQ-035 wr_ready=0 held, 2 more bytes after pixel completes -> first byte in skid, second byte_drop=1; release wr_ready -> skid byte becomes lane 0 of next pixel.
REQ-036 BYTE_TIMEOUT=10, one byte then silence -> timeout_err pulse after 10 cycles, count 0; next 3 bytes form a pixel at unchanged wr_addr.
REQ-037 frame_sync during WRITE with wr_ready=0 at wr_addr=5 -> next cycle wr_en=0, wr_addr=0, no frame_done.

Source files
------------

// File: rtl/uart_pixel_assembler.sv
// uart_pixel_assembler
//   Packs a stream of received UART bytes into pixel words and writes them to
//   sequential RAM addresses. Bytes fill byte lanes in arrival order. A full
//   pixel is then presented as a write request that is held until the RAM
//   accepts it. While a write is pending, one further byte is parked in a skid
//   register. A byte that cannot be parked is dropped and reported. A partial
//   pixel that stalls for too long is discarded and reported.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   rx_valid     one-cycle strobe qualifying data_in
//   data_in[7:0] received byte
//   frame_sync   one-cycle strobe: restart the frame at address 0
//   wr_ready     RAM accepts a write this cycle
//   wr_en        write request, held until accepted
//   wr_data      assembled pixel (DW bits)
//   wr_addr      pixel address (AW bits)
//   frame_done   one-cycle pulse after the last address of a frame is written
//   byte_drop    one-cycle pulse, byte lost because the skid register was full
//   timeout_err  one-cycle pulse, partial pixel discarded on inter-byte timeout
module uart_pixel_assembler #(
  parameter int PIXEL_COUNT     = 172800,
  parameter int BYTES_PER_PIXEL = 3,
  parameter int LSB_FIRST       = 1,
  parameter int BYTE_TIMEOUT    = 1000000,
  localparam int AW = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1,
  localparam int DW = 8 * BYTES_PER_PIXEL
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_valid,
  input  logic [7:0]    data_in,
  input  logic          frame_sync,
  input  logic          wr_ready,
  output logic          wr_en,
  output logic [DW-1:0] wr_data,
  output logic [AW-1:0] wr_addr,
  output logic          frame_done,
  output logic          byte_drop,
  output logic          timeout_err
);

  localparam int CW = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
  localparam int TW = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT + 1) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(BYTES_PER_PIXEL - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(PIXEL_COUNT - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(BYTE_TIMEOUT - 1);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_WRITE   = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   lanes_q, lanes_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      skid_q, skid_d;
  logic            skid_vld_q, skid_vld_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            frame_done_q, frame_done_d;
  logic            byte_drop_q, byte_drop_d;
  logic            timeout_err_q, timeout_err_d;

  // Per-cycle events shared between the datapath and the FSM.
  logic            pix_done;
  logic            wr_done;

  // In COLLECT up to two bytes can be taken in one cycle: the parked skid
  // byte (always first) and a freshly received byte.
  logic            byte_a_vld;
  logic [7:0]      byte_a;
  logic            byte_b_vld;

  // Place byte b into the lane addressed by byte position pos.
  function automatic logic [DW-1:0] put_byte(input logic [DW-1:0] w,
                                             input int pos,
                                             input logic [7:0] b);
    int lane;
    lane = (LSB_FIRST != 0) ? pos : (BYTES_PER_PIXEL - 1 - pos);
    w[8*lane +: 8] = b;
    return w;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_COLLECT;
      cnt_q         <= '0;
      lanes_q       <= '0;
      addr_q        <= '0;
      skid_vld_q    <= 1'b0;
      tmo_q         <= '0;
      frame_done_q  <= 1'b0;
      byte_drop_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lanes_q       <= lanes_d;
      addr_q        <= addr_d;
      skid_vld_q    <= skid_vld_d;
      tmo_q         <= tmo_d;
      frame_done_q  <= frame_done_d;
      byte_drop_q   <= byte_drop_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // The parked byte is only meaningful while skid_vld_q is set.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (frame_sync) begin
      state_d = S_COLLECT;
    end else begin
      case (state_q)
        S_COLLECT: if (pix_done) state_d = S_WRITE;
        S_WRITE:   if (wr_done)  state_d = S_COLLECT;
        default:   state_d = S_COLLECT;
      endcase
    end
  end

  // Datapath next values
  always_comb begin
    cnt_d         = cnt_q;
    lanes_d       = lanes_q;
    addr_d        = addr_q;
    skid_d        = skid_q;
    skid_vld_d    = skid_vld_q;
    tmo_d         = tmo_q;
    frame_done_d  = 1'b0;
    byte_drop_d   = 1'b0;
    timeout_err_d = 1'b0;
    pix_done      = 1'b0;
    wr_done       = 1'b0;
    byte_a_vld    = 1'b0;
    byte_a        = data_in;
    byte_b_vld    = 1'b0;

    if (frame_sync) begin
      // Restart wins over everything, including a byte in this same cycle.
      cnt_d      = '0;
      lanes_d    = '0;
      addr_d     = '0;
      skid_vld_d = 1'b0;
      tmo_d      = '0;
    end else if (state_q == S_COLLECT) begin
      if (skid_vld_q) begin
        byte_a     = skid_q;
        byte_a_vld = 1'b1;
        byte_b_vld = rx_valid;
        skid_vld_d = 1'b0;
      end else begin
        byte_a     = data_in;
        byte_a_vld = rx_valid;
      end

      if (byte_a_vld) begin
        tmo_d   = '0;
        lanes_d = put_byte(lanes_q, int'(cnt_q), byte_a);
        if (cnt_q == CNT_LAST) begin
          pix_done = 1'b1;
          cnt_d    = '0;
          // The second byte belongs to the next pixel; park it.
          if (byte_b_vld) begin
            skid_d     = data_in;
            skid_vld_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (byte_b_vld) begin
            lanes_d = put_byte(lanes_d, int'(cnt_q) + 1, data_in);
            if (cnt_q + CW'(1) == CNT_LAST) begin
              pix_done = 1'b1;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + CW'(2);
            end
          end
        end
      end else if (cnt_q != '0) begin
        // Inter-byte timeout only runs while a pixel is partially filled.
        if (tmo_q == TMO_LAST) begin
          cnt_d         = '0;
          lanes_d       = '0;
          tmo_d         = '0;
          timeout_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
    end else begin
      if (wr_ready) begin
        wr_done = 1'b1;
        cnt_d   = '0;
        if (addr_q == ADDR_LAST) begin
          addr_d       = '0;
          frame_done_d = 1'b1;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      if (rx_valid) begin
        if (!skid_vld_q) begin
          skid_d     = data_in;
          skid_vld_d = 1'b1;
        end else begin
          byte_drop_d = 1'b1;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    wr_en       = (state_q == S_WRITE);
    wr_data     = lanes_q;
    wr_addr     = addr_q;
    frame_done  = frame_done_q;
    byte_drop   = byte_drop_q;
    timeout_err = timeout_err_q;
  end

endmodule

// File: tb/tb_uart_pixel_assembler.sv
module tb_uart_pixel_assembler;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  data_in;
  logic        frame_sync;
  logic        wr_ready;

  logic        wr_en_a, frame_done_a, byte_drop_a, timeout_err_a;
  logic [23:0] wr_data_a;
  logic [1:0]  wr_addr_a;
  logic        wr_en_b, frame_done_b, byte_drop_b, timeout_err_b;
  logic [23:0] wr_data_b;
  logic [1:0]  wr_addr_b;

  always #5 clk = ~clk;

  uart_pixel_assembler #(
    .PIXEL_COUNT(4), .BYTES_PER_PIXEL(3), .LSB_FIRST(1), .BYTE_TIMEOUT(10)
  ) u_dut_a (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .data_in(data_in),
    .frame_sync(frame_sync), .wr_ready(wr_ready), .wr_en(wr_en_a),
    .wr_data(wr_data_a), .wr_addr(wr_addr_a), .frame_done(frame_done_a),
    .byte_drop(byte_drop_a), .timeout_err(timeout_err_a)
  );

  uart_pixel_assembler #(
    .PIXEL_COUNT(4), .BYTES_PER_PIXEL(3), .LSB_FIRST(0), .BYTE_TIMEOUT(10)
  ) u_dut_b (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .data_in(data_in),
    .frame_sync(frame_sync), .wr_ready(wr_ready), .wr_en(wr_en_b),
    .wr_data(wr_data_b), .wr_addr(wr_addr_b), .frame_done(frame_done_b),
    .byte_drop(byte_drop_b), .timeout_err(timeout_err_b)
  );

  // Observation word: {wr_en, wr_data, wr_addr, frame_done, byte_drop, timeout_err}
  logic [29:0] obs_a, obs_b;
  assign obs_a = {wr_en_a, wr_data_a, wr_addr_a, frame_done_a, byte_drop_a, timeout_err_a};
  assign obs_b = {wr_en_b, wr_data_b, wr_addr_b, frame_done_b, byte_drop_b, timeout_err_b};

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        fs;
    logic        rdy;
    logic        en;
    logic [23:0] data;
    logic [1:0]  addr;
    logic        fd;
    logic        bd;
    logic        te;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic add(input logic v, input logic [7:0] d, input logic fs, input logic rdy,
                     input logic en, input logic [23:0] data, input logic [1:0] addr,
                     input logic fd, input logic bd, input logic te);
    vec_t r;
    r.v = v; r.d = d; r.fs = fs; r.rdy = rdy;
    r.en = en; r.data = data; r.addr = addr; r.fd = fd; r.bd = bd; r.te = te;
    tbl.push_back(r);
  endtask

  task automatic check(input string name, input logic [29:0] act, input logic [29:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic fs, input logic rdy);
    rx_valid   = v;
    data_in    = d;
    frame_sync = fs;
    wr_ready   = rdy;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] swap3(input logic [23:0] x);
    return {x[7:0], x[15:8], x[23:16]};
  endfunction

  logic te_seen;

  initial begin
    reset = 1'b1; rx_valid = 1'b0; data_in = 8'h00; frame_sync = 1'b0; wr_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("reset_a", obs_a, 30'h0);
    check("reset_b", obs_b, 30'h0);
    reset = 1'b0;

    // v, d, fs, rdy | en, data, addr, fd, bd, te
    // basic pixel, immediate accept
    add(1,8'h11,0,1, 0,24'h000011,0,0,0,0);
    add(1,8'h22,0,1, 0,24'h002211,0,0,0,0);
    add(1,8'h33,0,1, 1,24'h332211,0,0,0,0);
    add(0,8'h00,0,1, 0,24'h332211,1,0,0,0);
    add(1,8'h44,0,1, 0,24'h332244,1,0,0,0);
    add(1,8'h55,0,1, 0,24'h335544,1,0,0,0);
    add(1,8'h66,0,1, 1,24'h665544,1,0,0,0);
    add(0,8'h00,0,1, 0,24'h665544,2,0,0,0);
    // write held one cycle by wr_ready=0
    add(1,8'h77,0,1, 0,24'h665577,2,0,0,0);
    add(1,8'h88,0,1, 0,24'h668877,2,0,0,0);
    add(1,8'h99,0,1, 1,24'h998877,2,0,0,0);
    add(0,8'h00,0,0, 1,24'h998877,2,0,0,0);
    add(0,8'h00,0,1, 0,24'h998877,3,0,0,0);
    // last address: wrap and frame_done
    add(1,8'hAA,0,1, 0,24'h9988AA,3,0,0,0);
    add(1,8'hBB,0,1, 0,24'h99BBAA,3,0,0,0);
    add(1,8'hCC,0,1, 1,24'hCCBBAA,3,0,0,0);
    add(0,8'h00,0,1, 0,24'hCCBBAA,0,1,0,0);
    add(0,8'h00,0,1, 0,24'hCCBBAA,0,0,0,0);
    // skid fill, overflow drop, skid byte becomes lane 0
    add(1,8'h01,0,0, 0,24'hCCBB01,0,0,0,0);
    add(1,8'h02,0,0, 0,24'hCC0201,0,0,0,0);
    add(1,8'h03,0,0, 1,24'h030201,0,0,0,0);
    add(1,8'h04,0,0, 1,24'h030201,0,0,0,0);
    add(1,8'h05,0,0, 1,24'h030201,0,0,1,0);
    add(0,8'h00,0,0, 1,24'h030201,0,0,0,0);
    add(0,8'h00,0,1, 0,24'h030201,1,0,0,0);
    add(0,8'h00,0,1, 0,24'h030204,1,0,0,0);
    add(1,8'h06,0,1, 0,24'h030604,1,0,0,0);
    add(1,8'h07,0,1, 1,24'h070604,1,0,0,0);
    add(0,8'h00,0,1, 0,24'h070604,2,0,0,0);
    // skid byte and new byte consumed together
    add(1,8'h08,0,1, 0,24'h070608,2,0,0,0);
    add(1,8'h09,0,1, 0,24'h070908,2,0,0,0);
    add(1,8'h0A,0,0, 1,24'h0A0908,2,0,0,0);
    add(1,8'h0B,0,1, 0,24'h0A0908,3,0,0,0);
    add(1,8'h0C,0,1, 0,24'h0A0C0B,3,0,0,0);
    add(1,8'h0D,0,1, 1,24'h0D0C0B,3,0,0,0);
    add(0,8'h00,0,1, 0,24'h0D0C0B,0,1,0,0);
    add(0,8'h00,0,1, 0,24'h0D0C0B,0,0,0,0);
    // frame_sync during a stalled write, byte with frame_sync ignored
    add(1,8'hE1,0,1, 0,24'h0D0CE1,0,0,0,0);
    add(1,8'hE2,0,1, 0,24'h0DE2E1,0,0,0,0);
    add(1,8'hE3,0,0, 1,24'hE3E2E1,0,0,0,0);
    add(0,8'h00,0,0, 1,24'hE3E2E1,0,0,0,0);
    add(0,8'h00,0,1, 0,24'hE3E2E1,1,0,0,0);
    add(1,8'hF1,0,1, 0,24'hE3E2F1,1,0,0,0);
    add(1,8'hF2,0,1, 0,24'hE3F2F1,1,0,0,0);
    add(1,8'hF3,0,0, 1,24'hF3F2F1,1,0,0,0);
    add(1,8'hF4,1,0, 0,24'h000000,0,0,0,0);
    add(0,8'h00,0,1, 0,24'h000000,0,0,0,0);
    add(1,8'h21,0,1, 0,24'h000021,0,0,0,0);
    add(1,8'h22,0,1, 0,24'h002221,0,0,0,0);
    add(1,8'h23,0,1, 1,24'h232221,0,0,0,0);
    add(0,8'h00,0,1, 0,24'h232221,1,0,0,0);
    // frame_sync mid-pixel restarts at lane 0, address 0
    add(1,8'h31,0,1, 0,24'h232231,1,0,0,0);
    add(0,8'h00,1,1, 0,24'h000000,0,0,0,0);
    add(1,8'h41,0,1, 0,24'h000041,0,0,0,0);
    add(1,8'h42,0,1, 0,24'h004241,0,0,0,0);
    add(1,8'h43,0,1, 1,24'h434241,0,0,0,0);
    add(0,8'h00,0,1, 0,24'h434241,1,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].fs, tbl[i].rdy);
      check($sformatf("vec%0d", i), obs_a,
            {tbl[i].en, tbl[i].data, tbl[i].addr, tbl[i].fd, tbl[i].bd, tbl[i].te});
      if (tbl[i].en)
        check($sformatf("vec%0d_msb_first", i), obs_b,
              {1'b1, swap3(tbl[i].data), tbl[i].addr, tbl[i].fd, tbl[i].bd, tbl[i].te});
    end

    // Inter-byte timeout: one byte, then silence for exactly BYTE_TIMEOUT cycles.
    step(1, 8'h51, 0, 1);
    check("tmo_first_byte", obs_a, {1'b0, 24'h434251, 2'd1, 3'b000});
    te_seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step(0, 8'h00, 0, 1);
      te_seen = te_seen | timeout_err_a;
    end
    check("tmo_early", {29'd0, te_seen}, 30'd0);
    step(0, 8'h00, 0, 1);
    check("tmo_fire", obs_a, {1'b0, 24'h000000, 2'd1, 3'b001});
    step(0, 8'h00, 0, 1);
    check("tmo_pulse_end", obs_a, {1'b0, 24'h000000, 2'd1, 3'b000});
    step(1, 8'h61, 0, 0);
    step(1, 8'h62, 0, 0);
    step(1, 8'h63, 0, 0);
    check("tmo_next_pixel", obs_a, {1'b1, 24'h636261, 2'd1, 3'b000});

    // No timeout while a write is stalled.
    te_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(0, 8'h00, 0, 0);
      te_seen = te_seen | timeout_err_a;
    end
    check("no_tmo_in_write", {wr_en_a, 28'd0, te_seen}, {1'b1, 29'd0});
    step(0, 8'h00, 0, 1);
    check("tmo_pixel_written", obs_a, {1'b0, 24'h636261, 2'd2, 3'b000});

    // No timeout while idle with no partial pixel.
    te_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(0, 8'h00, 0, 1);
      te_seen = te_seen | timeout_err_a;
    end
    check("no_tmo_idle", {29'd0, te_seen}, 30'd0);

    // Reset in the middle of a pixel discards it.
    step(1, 8'h71, 0, 1);
    step(1, 8'h72, 0, 1);
    check("pre_reset", obs_a, {1'b0, 24'h637271, 2'd2, 3'b000});
    reset = 1'b1;
    step(1, 8'h73, 0, 1);
    check("mid_reset_a", obs_a, 30'h0);
    check("mid_reset_b", obs_b, 30'h0);
    reset = 1'b0;
    step(1, 8'h81, 0, 1);
    check("post_reset_byte", obs_a, {1'b0, 24'h000081, 2'd0, 3'b000});
    step(0, 8'h00, 0, 1);
    check("post_reset_no_write", obs_a, {1'b0, 24'h000081, 2'd0, 3'b000});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
